// File: rtl/fourbit_1to4_demux_buf_pkg.sv
// -----------------------------------------------------------------------------
// fourbit_1to4_demux_buf_pkg
// Shared definitions for the 1-to-4 demultiplexing lane buffer:
//   - lane_e     : 2-bit lane index (A=0, B=1, C=2, D=3)
//   - DATA_W     : lane data width
//   - CNT_W      : accept counter width
//   - sel_lane() : maps the manual select pins {s1,s2} onto a lane index
// -----------------------------------------------------------------------------
package fourbit_1to4_demux_buf_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_e;

  // The manual select is not a plain binary index: s2 picks the A/B vs C/D
  // half and s1 picks within it, so 01 -> C and 10 -> B.
  function automatic lane_e sel_lane(input logic s1, input logic s2);
    case ({s1, s2})
      2'b00:   sel_lane = LANE_A;
      2'b01:   sel_lane = LANE_C;
      2'b10:   sel_lane = LANE_B;
      default: sel_lane = LANE_D;
    endcase
  endfunction

endpackage

// File: rtl/fourbit_1to4_demux_buf_lane.sv
// -----------------------------------------------------------------------------
// demux_lane_buf
// One-entry output buffer (data + valid) for a single demux lane.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : write din into the entry (takes priority over ack)
//   ack        : consumer takes the held word; ignored when valid is low
//   din        : word to load
//   data       : held word; kept after valid clears
//   valid      : entry holds an undelivered word
// -----------------------------------------------------------------------------
module demux_lane_buf
  import fourbit_1to4_demux_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              ack,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering; the data register is reset
  // too because its value is visible on an output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as an ack replaces the word and stays valid.
      data  <= din;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fourbit_1to4_demux_buf.sv
// -----------------------------------------------------------------------------
// fourbit_1to4_demux_buf
// Routes a 4-bit source word into one of four single-entry lane buffers.
// The target lane comes from a round-robin pointer (rr_en=1) or from the
// s1/s2 pins (rr_en=0). A word is accepted when din_valid && din_ready.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   din, din_valid         : offered source word
//   din_ready              : combinational; target lane empty or being acked
//   s1, s2                 : manual lane select (rr_en=0)
//   rr_en                  : 1 = round-robin, 0 = manual select
//   a, b, c, d             : registered lane data
//   a_valid .. d_valid     : lane holds an undelivered word
//   a_ack .. d_ack         : lane consumer takes the word this cycle
//   acc_cnt                : wrapping count of accepted words
// -----------------------------------------------------------------------------
module fourbit_1to4_demux_buf
  import fourbit_1to4_demux_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              s1,
  input  logic              s2,
  input  logic              rr_en,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic              a_valid,
  output logic              b_valid,
  output logic              c_valid,
  output logic              d_valid,
  input  logic              a_ack,
  input  logic              b_ack,
  input  logic              c_ack,
  input  logic              d_ack,
  output logic [CNT_W-1:0]  acc_cnt
);

  lane_e             rr_ptr;
  lane_e             target;
  logic              accept;
  logic [3:0]        lane_valid;
  logic [3:0]        lane_ack;
  logic [3:0]        lane_load;
  logic [DATA_W-1:0] lane_data [4];

  assign lane_ack = {d_ack, c_ack, b_ack, a_ack};

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    target = rr_ptr;
    if (!rr_en) target = sel_lane(s1, s2);
  end

  // A full lane can still accept when its consumer drains it this cycle.
  // The round-robin pointer never skips a stalled lane.
  assign din_ready = ~lane_valid[target] | lane_ack[target];
  assign accept    = din_valid & din_ready;
  assign lane_load = accept ? (4'b0001 << target) : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    demux_lane_buf u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[i]),
      .ack   (lane_ack[i]),
      .din   (din),
      .data  (lane_data[i]),
      .valid (lane_valid[i])
    );
  end

  // The pointer moves only on round-robin accepts and survives rr_en changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= LANE_A;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
      if (rr_en) rr_ptr <= lane_e'(rr_ptr + 2'd1);
    end
  end

  assign a       = lane_data[LANE_A];
  assign b       = lane_data[LANE_B];
  assign c       = lane_data[LANE_C];
  assign d       = lane_data[LANE_D];
  assign a_valid = lane_valid[LANE_A];
  assign b_valid = lane_valid[LANE_B];
  assign c_valid = lane_valid[LANE_C];
  assign d_valid = lane_valid[LANE_D];

endmodule

// File: tb/tb_fourbit_1to4_demux_buf.sv
// -----------------------------------------------------------------------------
// tb_fourbit_1to4_demux_buf
// Bench for fourbit_1to4_demux_buf: a behavioural model of four one-word
// mailboxes, a round-robin counter and an accept counter, compared against the
// DUT on every falling clock edge, plus directed scenarios with literal
// expectations and a randomized phase.
// -----------------------------------------------------------------------------
module tb_fourbit_1to4_demux_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       s1 = 1'b0, s2 = 1'b0, rr_en = 1'b0;
  logic [3:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic [3:0] ack = '0;   // {d,c,b,a}
  logic [7:0] acc_cnt;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  fourbit_1to4_demux_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .s1        (s1),
    .s2        (s2),
    .rr_en     (rr_en),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .c_valid   (c_valid),
    .d_valid   (d_valid),
    .a_ack     (ack[0]),
    .b_ack     (ack[1]),
    .c_ack     (ack[2]),
    .d_ack     (ack[3]),
    .acc_cnt   (acc_cnt)
  );

  // ---------------------------------------------------------------------------
  // Model: four mailboxes indexed 0=a,1=b,2=c,3=d
  // ---------------------------------------------------------------------------
  int m_data [4] = '{0, 0, 0, 0};
  bit m_full [4] = '{0, 0, 0, 0};
  int m_ptr = 0;
  int m_cnt = 0;
  int sel_map [4] = '{0, 2, 1, 3};  // {s1,s2}: 00->a 01->c 10->b 11->d

  function automatic int m_target();
    return rr_en ? m_ptr : sel_map[{s1, s2}];
  endfunction

  function automatic bit m_ready();
    int t = m_target();
    return !m_full[t] || ack[t];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i] = 0;
        m_full[i] = 1'b0;
      end
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      int  t;
      bit  take;
      t    = m_target();
      take = din_valid && m_ready();
      for (int i = 0; i < 4; i++) begin
        if (take && t == i) begin
          m_data[i] = int'(din);
          m_full[i] = 1'b1;
        end else if (ack[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (take) begin
        m_cnt = (m_cnt + 1) % 256;
        if (rr_en) m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp a",         int'(a),         m_data[0]);
      check("cmp b",         int'(b),         m_data[1]);
      check("cmp c",         int'(c),         m_data[2]);
      check("cmp d",         int'(d),         m_data[3]);
      check("cmp a_valid",   int'(a_valid),   int'(m_full[0]));
      check("cmp b_valid",   int'(b_valid),   int'(m_full[1]));
      check("cmp c_valid",   int'(c_valid),   int'(m_full[2]));
      check("cmp d_valid",   int'(d_valid),   int'(m_full[3]));
      check("cmp acc_cnt",   int'(acc_cnt),   m_cnt);
      check("cmp din_ready", int'(din_ready), int'(m_ready()));
    end
  end

  // Advance one clock; inputs change and literal checks happen 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic offer(input logic [3:0] w, input logic ss1, input logic ss2);
    din = w; din_valid = 1'b1; s1 = ss1; s2 = ss2;
  endtask

  initial begin
    #2;
    rst_n = 1'b1;
    do_reset();
    cmp_on = 1'b1;

    // Reset state
    check("reset a_valid", int'(a_valid), 0);
    check("reset acc_cnt", int'(acc_cnt), 0);
    check("reset d",       int'(d),       0);

    // Manual select: 00->a, 01->c, 10->b, 11->d with all acks high
    rr_en = 1'b0; ack = 4'hF;
    offer(4'd1, 1'b0, 1'b0); step();
    check("sel00 a", int'(a), 1); check("sel00 a_valid", int'(a_valid), 1);
    offer(4'd2, 1'b0, 1'b1); step();
    check("sel01 c", int'(c), 2); check("sel01 c_valid", int'(c_valid), 1);
    offer(4'd3, 1'b1, 1'b0); step();
    check("sel10 b", int'(b), 3); check("sel10 b_valid", int'(b_valid), 1);
    offer(4'd4, 1'b1, 1'b1); step();
    check("sel11 d", int'(d), 4); check("sel11 d_valid", int'(d_valid), 1);
    check("sel acc_cnt", int'(acc_cnt), 4);
    din_valid = 1'b0; ack = '0;
    step();
    check("hold a after ack", int'(a), 1);

    // Round-robin from a fresh reset, no acks
    do_reset();
    rr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(4'(5 + i), 1'b1, 1'b1);
      step();
    end
    check("rr a", int'(a), 5); check("rr b", int'(b), 6);
    check("rr c", int'(c), 7); check("rr d", int'(d), 8);
    offer(4'd9, 1'b0, 1'b0);
    #1 check("rr stall ready", int'(din_ready), 0);
    step();
    check("rr stall a kept", int'(a), 5);
    check("rr stall cnt",    int'(acc_cnt), 4);

    // Ack on a together with the new word: accepted, a stays valid
    ack = 4'b0001;
    #1 check("rr ack ready", int'(din_ready), 1);
    step();
    ack = '0;
    check("rr ack a",       int'(a),       9);
    check("rr ack a_valid", int'(a_valid), 1);

    // Manual select onto full d without ack: stall, a/b/c untouched
    rr_en = 1'b0;
    offer(4'hE, 1'b1, 1'b1);
    #1 check("d full ready", int'(din_ready), 0);
    step();
    check("d full a", int'(a), 9);
    check("d full b", int'(b), 6);
    check("d full c", int'(c), 7);
    check("d full d", int'(d), 8);
    din_valid = 1'b0;

    // Counter wrap: 256 consecutive accepts
    do_reset();
    rr_en = 1'b1; ack = 4'hF;
    for (int i = 0; i < 255; i++) begin
      offer(4'($urandom_range(0, 15)), 1'b0, 1'b0);
      step();
    end
    check("cnt 255", int'(acc_cnt), 255);
    step();
    check("cnt wrap", int'(acc_cnt), 0);
    offer(4'd3, 1'b0, 1'b0); step();
    offer(4'd7, 1'b0, 1'b0); step();
    ack = '0;
    offer(4'hA, 1'b0, 1'b0); step();
    din_valid = 1'b0;

    // Asynchronous reset between edges, pointer was away from a
    #2 rst_n = 1'b0;
    #1;
    check("async a_valid", int'(a_valid), 0);
    check("async c",       int'(c),       0);
    check("async acc_cnt", int'(acc_cnt), 0);
    #2 rst_n = 1'b1;
    step();
    offer(4'hB, 1'b1, 1'b1);
    step();
    din_valid = 1'b0;
    check("post reset a",       int'(a),       11);
    check("post reset a_valid", int'(a_valid), 1);
    check("post reset b_valid", int'(b_valid), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      din       = 4'($urandom_range(0, 15));
      din_valid = ($urandom_range(0, 3) != 0);
      s1        = 1'($urandom_range(0, 1));
      s2        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
      for (int k = 0; k < 4; k++) ack[k] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end

    din_valid = 1'b0;
    step();
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fourbit_1to4_demux_buf.md
FOURBIT_1TO4_DEMUX_BUF -- requirements
Module: fourbit_1to4_demux_buf

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port din, input, 4 bits: source word.
REQ-004 The block SHALL have the port din_valid, input, 1 bit: din is offered this cycle.
REQ-005 The block SHALL have the port din_ready, output, 1 bit: the offered word is accepted this cycle.
REQ-006 The block SHALL have the ports s1 and s2, inputs, 1 bit each: lane select, used only when rr_en=0.
REQ-007 The block SHALL have the port rr_en, input, 1 bit: 1 selects round-robin lane choice, 0 selects lane choice by s1/s2.
REQ-008 The block SHALL have the ports a, b, c, d, outputs, 4 bits each: registered lane data.
REQ-009 The block SHALL have the ports a_valid, b_valid, c_valid, d_valid, outputs, 1 bit each: the lane holds an undelivered word.
REQ-010 The block SHALL have the ports a_ack, b_ack, c_ack, d_ack, inputs, 1 bit each: the lane consumer takes the word this cycle.
REQ-011 The block SHALL have the port acc_cnt, output, 8 bits: running count of accepted words.

Function
REQ-012 The target lane SHALL be chosen as follows when rr_en=0: {s1,s2}=00 selects a, 01 selects c, 10 selects b, 11 selects d.
REQ-013 The target lane SHALL be chosen by the round-robin pointer rr_ptr when rr_en=1; rr_ptr steps a->b->c->d->a.
REQ-014 din_ready SHALL be combinational and SHALL equal (target lane valid==0) OR (target lane ack==1).
REQ-015 A word SHALL be accepted when din_valid AND din_ready are both high; the word then appears on the target lane output with its valid high on the next cycle, i.e. one-cycle latency.
REQ-016 A lane's valid SHALL clear on a cycle where its ack is high and no new word is loaded into that lane; a simultaneous ack and load SHALL keep valid high and replace the data.
REQ-017 An ack on a lane whose valid is low SHALL be ignored.
REQ-018 Lane data SHALL hold its value while valid is high and SHALL retain its last value after valid clears.
REQ-019 rr_ptr SHALL advance only on an accept with rr_en=1; rr_ptr SHALL NOT change while rr_en=0.
REQ-020 Changing rr_en SHALL NOT reset rr_ptr.
REQ-021 When rr_en=1 and the pointed lane is full and not acked, the block SHALL stall (din_ready=0) and SHALL NOT skip to another lane.
REQ-022 acc_cnt SHALL increment by 1 per accept and SHALL wrap from 255 to 0.
REQ-023 Lanes not targeted SHALL be unaffected by an accept.

Reset
REQ-024 On rst_n=0, all lane data SHALL clear to 0000, all lane valids to 0, rr_ptr to lane a, and acc_cnt to 0, immediately and without waiting for clk.
REQ-025 A word in flight when reset is asserted SHALL be discarded; after deassertion, the first accept SHALL target lane a in round-robin mode.

Structure
REQ-026 A shared package SHALL hold the 2-bit lane index encoding (LANE_A=0, LANE_B=1, LANE_C=2, LANE_D=3), the data width constant (4), and the counter width constant (8).
REQ-027 A single sub-module, demux_lane_buf (one-entry data+valid register with load/ack), SHALL be instantiated four times.

Verification
REQ-028 Scenario: rr_en=0; with s1s2 = 00, 01, 10, 11, offer din = 1, 2, 3, 4, one word per cycle, with all acks high. Required response: a=1, c=2, b=3, d=4, each one cycle after its accept; acc_cnt=4.
REQ-029 Scenario: rr_en=1; offer din = 5, 6, 7, 8, 9 with no acks. Required response: a=5, b=6, c=7, d=8; the fifth word stalls with din_ready=0.
REQ-030 Scenario: continuing from REQ-029, assert a_ack in the same cycle that din=9 is offered. Required response: accept in that cycle; a=9 and a_valid stays 1.
REQ-031 Scenario: rr_en=0, s1s2=11, d full, d_ack=0. Required response: din_ready=0 while lanes a, b and c stay idle and unchanged.
REQ-032 Scenario: 256 consecutive accepts. Required response: acc_cnt wraps to 0.
REQ-033 Scenario: assert rst_n=0 mid-stream, between clock edges. Required response: all outputs clear at once; after release, a round-robin accept goes to lane a.
